// File: rtl/wb_master_engine.sv
// Wishbone classic-cycle initiator.
// Takes one read/write request at a time on a valid/ready command port.
// Runs a single non-pipelined Wishbone cycle for it.
// Returns data and status on a valid/ready response port.
// Every output is a register; an asynchronous reset drops CYC/STB immediately.
module wb_master_engine #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [WB_ADDR_WIDTH-1:0]   req_addr,
    input  logic [WB_DATA_WIDTH-1:0]   req_data,
    input  logic [WB_DATA_WIDTH/8-1:0] req_sel,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WB_DATA_WIDTH-1:0]   rsp_data,
    output logic                       rsp_err,
    output logic                       rsp_timeout,
    output logic                       wb_cyc,
    output logic                       wb_stb,
    output logic                       wb_we,
    output logic [WB_ADDR_WIDTH-1:0]   wb_adr,
    output logic [WB_DATA_WIDTH-1:0]   wb_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0] wb_sel,
    input  logic [WB_DATA_WIDTH-1:0]   wb_dat_r,
    input  logic                       wb_ack,
    input  logic                       wb_err
);
    localparam int SW = WB_DATA_WIDTH / 8;
    // Keep the counter at least one bit wide even when the timeout is disabled.
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic                   req_ready_n, rsp_valid_n, rsp_err_n, rsp_timeout_n;
    logic [WB_DATA_WIDTH-1:0] rsp_data_n, wb_dat_w_n;
    logic                   wb_cyc_n, wb_stb_n, wb_we_n;
    logic [WB_ADDR_WIDTH-1:0] wb_adr_n;
    logic [SW-1:0]          wb_sel_n;

    // Next-state and next-output computation; every register holds by default.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        req_ready_n   = req_ready;
        rsp_valid_n   = rsp_valid;
        rsp_data_n    = rsp_data;
        rsp_err_n     = rsp_err;
        rsp_timeout_n = rsp_timeout;
        wb_cyc_n      = wb_cyc;
        wb_stb_n      = wb_stb;
        wb_we_n       = wb_we;
        wb_adr_n      = wb_adr;
        wb_dat_w_n    = wb_dat_w;
        wb_sel_n      = wb_sel;
        unique case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    state_n     = BUS;
                    req_ready_n = 1'b0;
                    cnt_n       = '0;
                    wb_cyc_n    = 1'b1;
                    wb_stb_n    = 1'b1;
                    wb_we_n     = req_we;
                    wb_adr_n    = req_addr;
                    wb_dat_w_n  = req_data;
                    wb_sel_n    = req_sel;
                end
            end
            BUS: begin
                // ERR outranks ACK; either outranks the timeout on the same edge.
                if (wb_err || wb_ack || (TO_EN && cnt == TO_LAST)) begin
                    state_n       = RSP;
                    rsp_valid_n   = 1'b1;
                    rsp_err_n     = wb_err || !wb_ack;
                    rsp_timeout_n = !wb_err && !wb_ack;
                    rsp_data_n    = (!wb_err && wb_ack && !wb_we) ? wb_dat_r : '0;
                    wb_cyc_n      = 1'b0;
                    wb_stb_n      = 1'b0;
                    wb_we_n       = 1'b0;
                    wb_adr_n      = '0;
                    wb_dat_w_n    = '0;
                    wb_sel_n      = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RSP: begin
                if (rsp_valid && rsp_ready) begin
                    state_n       = IDLE;
                    req_ready_n   = 1'b1;
                    rsp_valid_n   = 1'b0;
                    rsp_data_n    = '0;
                    rsp_err_n     = 1'b0;
                    rsp_timeout_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counter and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            wb_we       <= 1'b0;
            wb_adr      <= '0;
            wb_dat_w    <= '0;
            wb_sel      <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            req_ready   <= req_ready_n;
            rsp_valid   <= rsp_valid_n;
            rsp_data    <= rsp_data_n;
            rsp_err     <= rsp_err_n;
            rsp_timeout <= rsp_timeout_n;
            wb_cyc      <= wb_cyc_n;
            wb_stb      <= wb_stb_n;
            wb_we       <= wb_we_n;
            wb_adr      <= wb_adr_n;
            wb_dat_w    <= wb_dat_w_n;
            wb_sel      <= wb_sel_n;
        end
    end
endmodule

// File: tb/tb_wb_master_engine.sv
// Directed bench for wb_master_engine with a scripted slave and a response scoreboard.
module tb_wb_master_engine;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_data;
    logic        wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic [3:0]  wb_sel;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        to;
    } rsp_t;
    rsp_t sb[$];

    int tests = 0;
    int fails = 0;

    // Values of the request held pending while a response is backpressured.
    logic        nx_we;
    logic [31:0] nx_addr, nx_data;
    logic [3:0]  nx_sel;

    wb_master_engine #(.WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_dat_w(wb_dat_w), .wb_sel(wb_sel), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for it to be taken, check the bus it drives.
    task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] sel);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data; req_sel = sel;
        while (!req_ready && n < 20) begin tick(); n++; end
        chk("req_ready_before_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("cyc_after_accept", wb_cyc, 1);
        chk("stb_after_accept", wb_stb, 1);
        chk("we", wb_we, we);
        chk("adr", wb_adr, addr);
        chk("dat_w", wb_dat_w, data);
        chk("sel", wb_sel, sel);
        chk("req_ready_in_bus", req_ready, 0);
    endtask

    // Scripted slave: responds on CYC cycle ack_at (0 = never); garbage DAT_R otherwise.
    task automatic run_slave(input int ack_at, input logic err, input logic ack_too,
                             input logic [31:0] rdata, input logic [31:0] addr, output int cycles);
        cycles = 0;
        while (wb_cyc && cycles < 20) begin
            cycles++;
            chk("adr_held", wb_adr, addr);
            if (cycles == ack_at) begin
                wb_err = err; wb_ack = !err || ack_too; wb_dat_r = rdata;
            end else begin
                wb_err = 1'b0; wb_ack = 1'b0; wb_dat_r = 32'hBAD0_0000 | cycles;
            end
            tick();
        end
        wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = 32'hFFFF_FFFF;
    endtask

    // Pop the expected response, hold it under backpressure for bp cycles, then drain.
    task automatic consume(input int bp);
        rsp_t e;
        chk("sb_has_entry", (sb.size() != 0), 1);
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_timeout", rsp_timeout, e.to);
        rsp_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            tick();
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, e.data);
            chk("bp_rsp_err", rsp_err, e.err);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_no_cyc", wb_cyc, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("drain_rsp_valid", rsp_valid, 0);
        chk("drain_rsp_data", rsp_data, 0);
        chk("drain_rsp_err", rsp_err, 0);
        chk("drain_req_ready", req_ready, 1);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] sel, input int ack_at, input logic err,
                          input logic ack_too, input logic [31:0] rdata, input int bp);
        rsp_t e;
        int   cyc_n, exp_cyc;
        logic answered;
        answered = (ack_at >= 1 && ack_at <= TO);
        exp_cyc  = answered ? ack_at : TO;
        e.err  = !answered || err;
        e.to   = !answered;
        e.data = (answered && !err && !we) ? rdata : 32'h0;
        sb.push_back(e);
        start_req(we, addr, data, sel);
        run_slave(ack_at, err, ack_too, rdata, addr, cyc_n);
        chk("cyc_cycles", cyc_n, exp_cyc);
        chk("cyc_dropped", wb_cyc, 0);
        chk("stb_dropped", wb_stb, 0);
        chk("adr_cleared", wb_adr, 0);
        chk("dat_w_cleared", wb_dat_w, 0);
        if (bp > 0) begin
            req_valid = 1'b1; req_we = nx_we; req_addr = nx_addr;
            req_data = nx_data; req_sel = nx_sel;
        end
        consume(bp);
    endtask

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_data = '0;
        req_sel = '0; rsp_ready = 1'b0; wb_ack = 1'b0; wb_err = 1'b0; wb_dat_r = '0;
        nx_we = 1'b1; nx_addr = 32'h500; nx_data = 32'hCAFE_F00D; nx_sel = 4'h3;
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cyc", wb_cyc, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_adr", wb_adr, 0);
        rstn = 1'b1;
        tick();
        chk("post_rst_req_ready", req_ready, 1);

        // zero-wait write
        do_req(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1, 1'b0, 1'b0, 32'h0, 0);
        // read with three wait states; ack lands on the timeout edge and wins
        do_req(1'b0, 32'h204, 32'h0, 4'hF, 4, 1'b0, 1'b0, 32'h1234_5678, 0);
        // ERR alone, then ACK+ERR together
        do_req(1'b0, 32'h300, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'hAAAA_5555, 0);
        do_req(1'b0, 32'h304, 32'h0, 4'hF, 1, 1'b1, 1'b1, 32'h5555_AAAA, 0);
        // silent slave -> timeout; then a write acked on the last permitted cycle
        do_req(1'b0, 32'h400, 32'h0, 4'hF, 0, 1'b0, 1'b0, 32'h0, 0);
        do_req(1'b1, 32'h404, 32'h0BAD_CAFE, 4'hC, 4, 1'b0, 1'b0, 32'h0, 0);
        // backpressure with next request pending, then that request is taken at once
        do_req(1'b0, 32'h408, 32'h0, 4'hF, 2, 1'b0, 1'b0, 32'h7777_1111, 5);
        do_req(nx_we, nx_addr, nx_data, nx_sel, 1, 1'b0, 1'b0, 32'h0, 0);

        // reset while CYC is high, between clock edges
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h600; req_sel = 4'hF;
        tick();
        req_valid = 1'b0;
        chk("mid_cyc_up", wb_cyc, 1);
        #3 rstn = 1'b0;
        #1;
        chk("mid_rst_cyc", wb_cyc, 0);
        chk("mid_rst_stb", wb_stb, 0);
        chk("mid_rst_adr", wb_adr, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        #3 rstn = 1'b1;
        tick();
        chk("after_rst_req_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            wb_ack = 1'b1;
            tick();
            chk("no_stale_rsp", rsp_valid, 0);
            chk("no_stale_cyc", wb_cyc, 0);
        end
        wb_ack = 1'b0;
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
